// File: rtl/dom1_skinny_round_ctrl_pkg.sv
// Shared definitions for the DOM-1 Skinny-128-384+ round controller:
// controller state encoding, default round count, stage count and the
// round-constant update function.
package dom1_skinny_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    localparam logic [5:0] SKINNY_RC_INIT    = 6'h01;
    localparam int         SKINNY_NUM_ROUNDS = 40;
    localparam int         SKINNY_STAGES     = 4;

    // One step of the Skinny 6-bit round-constant LFSR
    function automatic logic [5:0] rc_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/dom1_skinny_rc_lfsr.sv
// 6-bit Skinny round-constant LFSR. load forces RC_INIT and has priority
// over step; step advances the sequence by one round.
module dom1_skinny_rc_lfsr
    import dom1_skinny_round_ctrl_pkg::*;
#(
    parameter logic [5:0] RC_INIT = SKINNY_RC_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [5:0] rc
);

    logic [5:0] rc_q;
    logic [5:0] rc_d;

    // Next constant: reload on start, advance on round boundary, else hold
    always_comb begin
        rc_d = rc_q;
        if (load) begin
            rc_d = RC_INIT;
        end else if (step) begin
            rc_d = rc_next(rc_q);
        end
    end

    // Constant register, restored to the round-0 value on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q <= RC_INIT;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc = rc_q;

endmodule

// File: rtl/dom1_skinny_round_ctrl.sv
// Round scheduler for the DOM-1 masked Skinny-128-384+ datapath. Each round
// takes four DOM pipeline stages; the controller sequences one-hot stage
// enables, the round-boundary reload strobe, the round constant, and the
// final store/done handshake towards the byte-serial I/O FSM.
// Optional feature macro: DOM1_SKINNY_RND_STALL_EN -- when defined, the
// pipeline only advances in cycles where fresh randomness (rnd_valid) is
// available; otherwise it advances every RUN cycle and rnd_valid is unused.
module dom1_skinny_round_ctrl
    import dom1_skinny_round_ctrl_pkg::*;
#(
    parameter int         NUM_ROUNDS = SKINNY_NUM_ROUNDS,
    parameter logic [5:0] RC_INIT    = SKINNY_RC_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnd_valid,
    output logic       busy,
    output logic [3:0] en,
    output logic       kstore,
    output logic [5:0] rc,
    output logic       rnd_req,
    output logic       store,
    output logic       done
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
    localparam logic [1:0] LAST_STAGE = 2'(SKINNY_STAGES - 1);

    ctrl_state_e state_q, state_d;
    logic [1:0]  stage_q, stage_d;
    logic [5:0]  round_q, round_d;
    logic        adv_ok;
    logic        rc_load;
    logic        rc_step;

`ifdef DOM1_SKINNY_RND_STALL_EN
    // Each stage consumes fresh masking randomness, so hold without it
    assign adv_ok = rnd_valid;
`else
    logic unused_rnd_valid;
    assign unused_rnd_valid = rnd_valid;
    assign adv_ok           = 1'b1;
`endif

    // Round constant generator
    dom1_skinny_rc_lfsr #(
        .RC_INIT (RC_INIT)
    ) u_rc_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (rc_load),
        .step (rc_step),
        .rc   (rc)
    );

    // Next-state, counter update and output decode
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        round_d = round_q;
        en      = 4'b0000;
        kstore  = 1'b0;
        store   = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        rnd_req = 1'b0;
        rc_load = 1'b0;
        rc_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = 2'd0;
                    round_d = 6'd0;
                    rc_load = 1'b1;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (adv_ok) begin
                    en      = 4'b0001 << stage_q;
                    rnd_req = 1'b1;
                    // Round 0 works on the externally loaded state
                    kstore  = (stage_q == 2'd0) && (round_q != 6'd0);
                    stage_d = stage_q + 2'd1;
                    if (stage_q == LAST_STAGE) begin
                        if (round_q == LAST_ROUND) begin
                            state_d = ST_STORE;
                        end else begin
                            round_d = round_q + 6'd1;
                            rc_step = 1'b1;
                        end
                    end
                end
            end
            ST_STORE: begin
                busy    = 1'b1;
                store   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and stage/round counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= 2'd0;
            round_q <= 6'd0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            round_q <= round_d;
        end
    end

endmodule

// File: tb/tb_dom1_skinny_round_ctrl.sv
// Directed bench for dom1_skinny_round_ctrl (NUM_ROUNDS=40).
module tb_dom1_skinny_round_ctrl;

    localparam int NR = 40;
`ifdef DOM1_SKINNY_RND_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rnd_valid;
    logic       busy;
    logic [3:0] en;
    logic       kstore;
    logic [5:0] rc;
    logic       rnd_req;
    logic       store;
    logic       done;

    int n_cmp;
    int n_err;
    int st, dn, nk, sd;

    bit start_at [0:511];
    bit vpat     [0:511];
    logic [5:0] rc_tab [0:6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D};

    dom1_skinny_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rnd_valid (rnd_valid),
        .busy      (busy),
        .en        (en),
        .kstore    (kstore),
        .rc        (rc),
        .rnd_req   (rnd_req),
        .store     (store),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pats();
        for (int i = 0; i < 512; i++) begin
            start_at[i] = 1'b0;
            vpat[i]     = 1'b1;
        end
    endtask

    // Caller is mid-cycle; start is sampled at the next edge (edge 0).
    // Cycle c is sampled 4 time units after edge c-1.
    task automatic run_block(input string tag, output int st_at, output int dn_at, output int nkst);
        int   nadv;
        int   p;
        int   post;
        logic eadv;
        logic [3:0] een;
        nadv  = 0;
        p     = 0;
        post  = 0;
        st_at = -1;
        dn_at = -1;
        nkst  = 0;
        start = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(posedge clk);
            #2;
            start     = start_at[c];
            rnd_valid = vpat[c];
            #2;
            eadv = (p == 0) && (!STALL_ON || vpat[c]);
            een  = eadv ? (4'b0001 << (nadv % 4)) : 4'b0000;
            chk({tag, ".en"},      32'(en),      32'(een));
            chk({tag, ".rnd_req"}, 32'(rnd_req), 32'(eadv));
            chk({tag, ".kstore"},  32'(kstore),  32'(eadv && (nadv % 4 == 0) && (nadv >= 4)));
            chk({tag, ".store"},   32'(store),   32'(p == 1));
            chk({tag, ".done"},    32'(done),    32'(p == 2));
            chk({tag, ".busy"},    32'(busy),    32'(p <= 1));
            if (p == 0 && nadv / 4 <= 6) chk({tag, ".rc"}, 32'(rc), 32'(rc_tab[nadv / 4]));
            if (kstore) nkst++;
            if (store && st_at < 0) st_at = c;
            if (done && dn_at < 0) dn_at = c;
            if (p == 0) begin
                if (eadv) nadv++;
                if (nadv == 4 * NR) p = 1;
            end else if (p == 1) begin
                p = 2;
            end else if (p == 2) begin
                p = 3;
            end else begin
                post++;
                if (post == 5) break;
            end
        end
        start     = 1'b0;
        rnd_valid = 1'b1;
        chk({tag, ".completed"}, 32'(p), 32'd3);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        rnd_valid = 1'b1;
        clear_pats();

        // Reset state
        repeat (2) @(posedge clk);
        #4;
        chk("rst.en",      32'(en),      32'd0);
        chk("rst.busy",    32'(busy),    32'd0);
        chk("rst.store",   32'(store),   32'd0);
        chk("rst.done",    32'(done),    32'd0);
        chk("rst.kstore",  32'(kstore),  32'd0);
        chk("rst.rnd_req", 32'(rnd_req), 32'd0);
        chk("rst.rc",      32'(rc),      32'h01);
        rst = 1'b0;
        @(posedge clk);
        #4;
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.en",   32'(en),   32'd0);

        // Nominal run, then immediate restart
        run_block("nom", st, dn, nk);
        chk("nom.store_cyc", 32'(st), 32'd161);
        chk("nom.done_cyc",  32'(dn), 32'd162);
        chk("nom.kstores",   32'(nk), 32'd39);
        run_block("restart", st, dn, nk);
        chk("restart.done_cyc", 32'(dn), 32'd162);

`ifdef DOM1_SKINNY_RND_STALL_EN
        // 3-cycle stall in stage 2 of round 5
        clear_pats();
        vpat[23] = 1'b0;
        vpat[24] = 1'b0;
        vpat[25] = 1'b0;
        run_block("stall3", st, dn, nk);
        chk("stall3.store_cyc", 32'(st), 32'd164);
        chk("stall3.done_cyc",  32'(dn), 32'd165);
        chk("stall3.kstores",   32'(nk), 32'd39);

        // Stalls on the first RUN cycle and on the last stage
        clear_pats();
        vpat[1]   = 1'b0;
        vpat[161] = 1'b0;
        vpat[162] = 1'b0;
        run_block("stallb", st, dn, nk);
        chk("stallb.store_cyc", 32'(st), 32'd164);
        chk("stallb.done_cyc",  32'(dn), 32'd165);
        chk("stallb.kstores",   32'(nk), 32'd39);
`else
        // rnd_valid toggling must not disturb timing
        clear_pats();
        for (int i = 0; i < 512; i++) vpat[i] = (i % 3 == 0);
        run_block("togl", st, dn, nk);
        chk("togl.done_cyc", 32'(dn), 32'd162);
        chk("togl.kstores",  32'(nk), 32'd39);
`endif

        // start pulses during RUN, STORE and DONE are ignored
        clear_pats();
        start_at[50]  = 1'b1;
        start_at[161] = 1'b1;
        start_at[162] = 1'b1;
        run_block("ign", st, dn, nk);
        chk("ign.done_cyc", 32'(dn), 32'd162);
        clear_pats();

        // Reset at round 20, stage 1 (cycle 82)
        start = 1'b1;
        for (int c = 1; c <= 82; c++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            #2;
        end
        chk("mid.en_before",   32'(en),   32'b0010);
        chk("mid.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #4;
        chk("mid.en",     32'(en),     32'd0);
        chk("mid.busy",   32'(busy),   32'd0);
        chk("mid.rc",     32'(rc),     32'h01);
        chk("mid.store",  32'(store),  32'd0);
        chk("mid.done",   32'(done),   32'd0);
        chk("mid.kstore", 32'(kstore), 32'd0);
        rst = 1'b0;
        sd  = 0;
        repeat (100) begin
            @(posedge clk);
            #4;
            if (store || done || busy) sd++;
        end
        chk("mid.quiet", 32'(sd), 32'd0);

        // Fresh run after reset completes normally
        run_block("post_rst", st, dn, nk);
        chk("post_rst.done_cyc", 32'(dn), 32'd162);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
